// File: rtl/la_pkg.sv
// la_pkg: shared definitions for the logic analyzer capture core.
// Holds the host opcodes, the capture/readout state encoding, the ID word
// returned to the host and the RAM geometry (32 channels x 32 entries).
package la_pkg;

    localparam int LA_WIDTH = 32;   // channels per sample
    localparam int LA_DEPTH = 32;   // sample RAM entries
    localparam int LA_AW    = 5;    // RAM address width

    localparam logic [7:0] OP_NOP     = 8'h00;
    localparam logic [7:0] OP_RUN     = 8'h01;
    localparam logic [7:0] OP_ID      = 8'h02;
    localparam logic [7:0] OP_SRST    = 8'h03;
    localparam logic [7:0] OP_MASK_LO = 8'hC0;
    localparam logic [7:0] OP_MASK_HI = 8'hC1;
    localparam logic [7:0] OP_VAL_LO  = 8'hC4;
    localparam logic [7:0] OP_VAL_HI  = 8'hC5;
    localparam logic [7:0] OP_DELAY   = 8'h81;

    localparam logic [31:0] LA_ID_WORD = 32'h534C4131;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEND_ID = 3'd1,
        ST_ARMED   = 3'd2,
        ST_DELAY   = 3'd3,
        ST_RD_ADDR = 3'd4,
        ST_RD_WAIT = 3'd5,
        ST_RD_SEND = 3'd6
    } la_state_e;

    // Replace one 16-bit half of a configuration word, leaving the other half.
    function automatic logic [31:0] set_half(input logic [31:0] cur,
                                             input logic        hi,
                                             input logic [15:0] half);
        logic [31:0] res;
        res = cur;
        if (hi) begin
            res[31:16] = half;
        end else begin
            res[15:0] = half;
        end
        return res;
    endfunction

endpackage

// File: rtl/la_trigger.sv
// la_trigger: combinational trigger compare.
// Ports: input_i (current sample), mask_i / value_i (trigger configuration),
//        hit_o (all masked channels equal the masked value; mask 0 always hits).
module la_trigger
    import la_pkg::*;
(
    input  logic [31:0] input_i,
    input  logic [31:0] mask_i,
    input  logic [31:0] value_i,
    output logic        hit_o
);

    // Channels outside the mask are don't-care on both sides of the compare.
    always_comb begin
        hit_o = ((input_i & mask_i) == (value_i & mask_i));
    end

endmodule

// File: rtl/la_core.sv
// la_core: command decode, trigger configuration, ring capture and newest-first
// readout for a SUMP-style logic analyzer.
// Ports: clk_i / rst_in (sync, active-high); cmd_i {opcode, arg} one-cycle
//        commands; input_i channel samples; tx_rdy_i transmitter ready;
//        mem_i RAM read data (one cycle after addr_o); we_o / addr_o / mem_o
//        RAM write port (addr_o also used for reads); tx_stb_o / tx_o
//        one-cycle transmit strobe and word.
module la_core
    import la_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_in,
    input  logic [31:0] cmd_i,
    input  logic [31:0] input_i,
    input  logic        tx_rdy_i,
    input  logic [31:0] mem_i,
    output logic        we_o,
    output logic [4:0]  addr_o,
    output logic [31:0] mem_o,
    output logic        tx_stb_o,
    output logic [31:0] tx_o
);

    localparam int REM_W = $clog2(LA_DEPTH) + 1;

    la_state_e              state_q, state_d;
    logic [LA_AW-1:0]       wptr_q, wptr_d;
    logic [LA_AW-1:0]       rptr_q, rptr_d;
    logic [LA_AW-1:0]       cnt_q, cnt_d;
    logic [LA_AW-1:0]       delay_q, delay_d;
    logic [LA_AW-1:0]       rdcnt_q, rdcnt_d;      // read count minus one
    logic [REM_W-1:0]       rem_q, rem_d;
    logic [LA_WIDTH-1:0]    mask_q, mask_d;
    logic [LA_WIDTH-1:0]    value_q, value_d;
    logic [LA_WIDTH-1:0]    data_q, data_d;

    logic [7:0]             opcode_s;
    logic [23:0]            arg_s;
    logic                   hit_s;
    logic [7:0]             unused_arg_s;

    assign opcode_s     = cmd_i[31:24];
    assign arg_s        = cmd_i[23:0];
    assign unused_arg_s = arg_s[23:16];

    la_trigger u_trigger (
        .input_i (input_i),
        .mask_i  (mask_q),
        .value_i (value_q),
        .hit_o   (hit_s)
    );

    // Next-state, pointer and configuration logic.
    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        cnt_d   = cnt_q;
        delay_d = delay_q;
        rdcnt_d = rdcnt_q;
        rem_d   = rem_q;
        mask_d  = mask_q;
        value_d = value_q;
        data_d  = data_q;

        if (opcode_s == OP_SRST) begin
            // Abort whatever is running; configuration survives.
            state_d = ST_IDLE;
            wptr_d  = 5'd0;
            rptr_d  = 5'd0;
            cnt_d   = 5'd0;
            rem_d   = 6'd0;
            data_d  = 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    case (opcode_s)
                        OP_NOP:     state_d = ST_IDLE;
                        OP_RUN: begin
                            state_d = ST_ARMED;
                            wptr_d  = 5'd0;
                        end
                        OP_ID:      state_d = ST_SEND_ID;
                        OP_MASK_LO: mask_d  = set_half(mask_q, 1'b0, arg_s[15:0]);
                        OP_MASK_HI: mask_d  = set_half(mask_q, 1'b1, arg_s[15:0]);
                        OP_VAL_LO:  value_d = set_half(value_q, 1'b0, arg_s[15:0]);
                        OP_VAL_HI:  value_d = set_half(value_q, 1'b1, arg_s[15:0]);
                        OP_DELAY: begin
                            delay_d = arg_s[4:0];
                            rdcnt_d = arg_s[12:8];
                        end
                        default:    state_d = ST_IDLE;
                    endcase
                end
                ST_SEND_ID: begin
                    if (tx_rdy_i) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_SEND_ID;
                    end
                end
                ST_ARMED: begin
                    wptr_d = wptr_q + 5'd1;
                    if (hit_s) begin
                        // The trigger sample is the one written this cycle.
                        rptr_d = wptr_q;
                        rem_d  = {1'b0, rdcnt_q} + 6'd1;
                        cnt_d  = delay_q;
                        if (delay_q == 5'd0) begin
                            state_d = ST_RD_ADDR;
                        end else begin
                            state_d = ST_DELAY;
                        end
                    end else begin
                        state_d = ST_ARMED;
                    end
                end
                ST_DELAY: begin
                    wptr_d = wptr_q + 5'd1;
                    if (cnt_q == 5'd1) begin
                        rptr_d  = wptr_q;
                        state_d = ST_RD_ADDR;
                    end else begin
                        cnt_d = cnt_q - 5'd1;
                    end
                end
                ST_RD_ADDR: state_d = ST_RD_WAIT;
                ST_RD_WAIT: begin
                    data_d  = mem_i;
                    state_d = ST_RD_SEND;
                end
                ST_RD_SEND: begin
                    if (tx_rdy_i) begin
                        if (rem_q == 6'd1) begin
                            state_d = ST_IDLE;
                        end else begin
                            rem_d   = rem_q - 6'd1;
                            rptr_d  = rptr_q - 5'd1;
                            state_d = ST_RD_ADDR;
                        end
                    end else begin
                        state_d = ST_RD_SEND;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State, pointer and configuration registers.
    always_ff @(posedge clk_i) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
            wptr_q  <= 5'd0;
            rptr_q  <= 5'd0;
            cnt_q   <= 5'd0;
            delay_q <= 5'd0;
            rdcnt_q <= 5'd0;
            rem_q   <= 6'd0;
            mask_q  <= 32'd0;
            value_q <= 32'd0;
            data_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            delay_q <= delay_d;
            rdcnt_q <= rdcnt_d;
            rem_q   <= rem_d;
            mask_q  <= mask_d;
            value_q <= value_d;
            data_q  <= data_d;
        end
    end

    // Output decode from registered state; the strobe is gated by tx_rdy_i
    // so it can never fire while the transmitter is busy.
    always_comb begin
        we_o     = 1'b0;
        addr_o   = 5'd0;
        mem_o    = 32'd0;
        tx_stb_o = 1'b0;
        tx_o     = 32'd0;
        case (state_q)
            ST_ARMED, ST_DELAY: begin
                we_o   = 1'b1;
                addr_o = wptr_q;
                mem_o  = input_i;
            end
            ST_RD_ADDR: addr_o = rptr_q;
            ST_SEND_ID: begin
                if (tx_rdy_i) begin
                    tx_stb_o = 1'b1;
                    tx_o     = LA_ID_WORD;
                end else begin
                    tx_stb_o = 1'b0;
                end
            end
            ST_RD_SEND: begin
                if (tx_rdy_i) begin
                    tx_stb_o = 1'b1;
                    tx_o     = data_q;
                end else begin
                    tx_stb_o = 1'b0;
                end
            end
            default: we_o = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_la_core.sv
// Self-checking bench for la_core: table of capture scenarios with hand
// expectations, hand-written abort/ID sequences and randomized runs, all
// compared against a sample-stream model of the capture ring.
module tb_la_core;

    localparam int          STIM_N  = 128;
    localparam logic [31:0] ID_WORD = 32'h534C4131;

    logic        clk_i = 1'b0;
    logic        rst_in;
    logic [31:0] cmd_i;
    logic [31:0] input_i;
    logic        tx_rdy_i;
    logic [31:0] mem_i;
    logic        we_o;
    logic [4:0]  addr_o;
    logic [31:0] mem_o;
    logic        tx_stb_o;
    logic [31:0] tx_o;

    la_core dut (
        .clk_i    (clk_i),
        .rst_in   (rst_in),
        .cmd_i    (cmd_i),
        .input_i  (input_i),
        .tx_rdy_i (tx_rdy_i),
        .mem_i    (mem_i),
        .we_o     (we_o),
        .addr_o   (addr_o),
        .mem_o    (mem_o),
        .tx_stb_o (tx_stb_o),
        .tx_o     (tx_o)
    );

    always #5 clk_i = ~clk_i;

    // Sample RAM: synchronous write, registered read.
    logic [31:0] ram [32];
    logic        ram_fill;
    always @(posedge clk_i) begin
        if (ram_fill) begin
            for (int i = 0; i < 32; i++) ram[i] <= 32'hF000_0000 | 32'(i);
        end else if (we_o) begin
            ram[addr_o] <= mem_o;
        end
        mem_i <= ram[addr_o];
    end

    // Observed writes and transmitted words, plus strobe rule violations.
    logic [36:0] wr_q [$];
    logic [31:0] tx_q [$];
    int          viol = 0;
    logic        prev_stb = 1'b0;
    always @(negedge clk_i) begin
        if (we_o === 1'b1) wr_q.push_back({addr_o, mem_o});
        if (tx_stb_o === 1'b1) begin
            tx_q.push_back(tx_o);
            if (prev_stb || !tx_rdy_i) viol <= viol + 1;
        end
        prev_stb <= (tx_stb_o === 1'b1);
    end

    // Model state: stimulus stream and expected RAM image.
    logic [31:0] stim [STIM_N];
    logic [31:0] mram [32];
    int          kidx = 0;
    bit          in_mode = 1'b0;
    int          wr_base, tx_base;
    int          n_pass = 0;
    int          n_total = 0;

    typedef struct {
        string       name;
        logic [31:0] mask;
        logic [31:0] value;
        int          dly;
        int          rc;
        bit          rnd;
        logic [31:0] base;
        int          exp_wr;
        logic [31:0] exp_first;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] tx_at(input int i);
        if (i < tx_q.size()) return tx_q[i];
        return 32'hDEAD_DEAD;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
        if (in_mode) begin
            input_i = (kidx < STIM_N) ? stim[kidx] : stim[STIM_N-1];
            kidx++;
        end
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [23:0] arg);
        cmd_i = {op, arg};
        tick();
        cmd_i = 32'd0;
    endtask

    task automatic configure(input logic [31:0] mask, input logic [31:0] value,
                             input int dly, input int rc);
        send_cmd(8'hC0, {8'h00, mask[15:0]});
        send_cmd(8'hC1, {8'h00, mask[31:16]});
        send_cmd(8'hC4, {8'h00, value[15:0]});
        send_cmd(8'hC5, {8'h00, value[31:16]});
        send_cmd(8'h81, {11'd0, 5'(rc - 1), 3'd0, 5'(dly)});
    endtask

    task automatic fill_ramp(input logic [31:0] base);
        for (int k = 0; k < STIM_N; k++) stim[k] = base + 32'(k);
    endtask

    // Index of the last sample written: first matching sample plus delay.
    function automatic int find_last(input logic [31:0] mask, input logic [31:0] value, input int dly);
        for (int k = 0; k < STIM_N; k++)
            if (((stim[k] ^ value) & mask) == 32'd0) return k + dly;
        return -1;
    endfunction

    task automatic start_run();
        wr_base = wr_q.size();
        tx_base = tx_q.size();
        kidx    = 0;
        in_mode = 1'b1;
        send_cmd(8'h01, 24'd0);
    endtask

    // Wait for the readout, then compare writes and words with the model.
    task automatic finish_run(input string name, input int n_wr, input int last_k,
                              input int rc, input bit rnd);
        int c;
        c = 0;
        while ((tx_q.size() - tx_base) < rc && c < 3000) begin
            tx_rdy_i = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            tick();
            c++;
        end
        tx_rdy_i = 1'b1;
        repeat (8) tick();
        for (int k = 0; k < n_wr; k++) mram[k % 32] = stim[k];
        check({name, "_nwr"}, 64'(wr_q.size() - wr_base), 64'(n_wr));
        for (int k = 0; k < n_wr && (wr_base + k) < wr_q.size(); k++)
            check($sformatf("%s_wr%0d", name, k), 64'(wr_q[wr_base + k]), 64'({5'(k), stim[k]}));
        check({name, "_ntx"}, 64'(tx_q.size() - tx_base), 64'(rc));
        for (int j = 0; j < rc; j++)
            check($sformatf("%s_tx%0d", name, j), 64'(tx_at(tx_base + j)), 64'(mram[(last_k - j) & 31]));
    endtask

    initial begin
        logic [31:0] m, v;
        int d, rc, last;

        tbl[0] = '{"immediate",   32'h0000_0000, 32'h0000_0000,  0,  4, 1'b0, 32'h0000_0100,  1, 32'h0000_0100};
        tbl[1] = '{"masked",      32'h0000_00FF, 32'h0000_00A5,  3,  1, 1'b0, 32'h0000_00A0,  9, 32'h0000_00A8};
        tbl[2] = '{"wrap",        32'hFFFF_FFFF, 32'h0000_1027,  0,  3, 1'b1, 32'h0000_1000, 40, 32'h0000_1027};
        tbl[3] = '{"max_delay",   32'h0000_0000, 32'h0000_0000, 31, 32, 1'b1, 32'h0000_2000, 32, 32'h0000_201F};
        tbl[4] = '{"low_nibble",  32'h0000_000F, 32'h0000_0007,  2,  5, 1'b0, 32'h0000_0050, 10, 32'h0000_0059};
        tbl[5] = '{"outside_msk", 32'h0000_00F0, 32'hFFFF_FF3C,  1,  2, 1'b1, 32'h0000_0030,  2, 32'h0000_0031};
        tbl[6] = '{"high_half",   32'hFFFF_0000, 32'h0001_0000,  0,  2, 1'b0, 32'h0000_FFF8,  9, 32'h0001_0000};

        // Reset.
        rst_in   = 1'b1;
        ram_fill = 1'b1;
        cmd_i    = 32'd0;
        tx_rdy_i = 1'b1;
        input_i  = 32'hFFFF_FFFF;
        repeat (3) tick();
        rst_in   = 1'b0;
        ram_fill = 1'b0;
        for (int i = 0; i < 32; i++) mram[i] = 32'hF000_0000 | 32'(i);
        tick();
        check("reset_ctrl", 64'({we_o, addr_o, tx_stb_o}), 64'd0);
        check("reset_mem_o", 64'(mem_o), 64'd0);
        check("reset_tx_o", 64'(tx_o), 64'd0);

        // ID with transmitter ready.
        tx_base = tx_q.size();
        send_cmd(8'h02, 24'd0);
        repeat (3) tick();
        check("id_count", 64'(tx_q.size() - tx_base), 64'd1);
        check("id_word", 64'(tx_at(tx_base)), 64'(ID_WORD));

        // ID with transmitter busy for 5 cycles.
        tx_rdy_i = 1'b0;
        tx_base  = tx_q.size();
        send_cmd(8'h02, 24'd0);
        repeat (5) tick();
        check("id_wait_nostrobe", 64'(tx_q.size() - tx_base), 64'd0);
        tx_rdy_i = 1'b1;
        #1;
        check("id_wait_strobe", 64'({tx_stb_o, tx_o}), 64'({1'b1, ID_WORD}));
        repeat (3) tick();
        check("id_wait_count", 64'(tx_q.size() - tx_base), 64'd1);

        // Table-driven capture scenarios.
        for (int t = 0; t < 7; t++) begin
            configure(tbl[t].mask, tbl[t].value, tbl[t].dly, tbl[t].rc);
            fill_ramp(tbl[t].base);
            last = find_last(tbl[t].mask, tbl[t].value, tbl[t].dly);
            start_run();
            finish_run(tbl[t].name, last + 1, last, tbl[t].rc, tbl[t].rnd);
            check({tbl[t].name, "_hand_nwr"}, 64'(wr_q.size() - wr_base), 64'(tbl[t].exp_wr));
            check({tbl[t].name, "_hand_first"}, 64'(tx_at(tx_base)), 64'(tbl[t].exp_first));
        end

        // Configuration is ignored while armed.
        configure(32'hFFFF_FFFF, 32'h0000_005A, 0, 1);
        fill_ramp(32'h0000_0050);
        start_run();
        tick();
        tick();
        send_cmd(8'hC0, 24'h000000);
        finish_run("cfg_ignored", 11, 10, 1, 1'b0);

        // Soft reset during DELAY aborts but keeps the configuration.
        configure(32'hFFFF_FFFF, 32'h0000_0300, 5, 1);
        fill_ramp(32'h0000_0300);
        start_run();
        tick();
        tick();
        send_cmd(8'h03, 24'd0);
        check("srst_we_off", 64'({we_o, addr_o, mem_o}), 64'd0);
        finish_run("srst_abort", 3, 0, 0, 1'b0);
        fill_ramp(32'h0000_02FC);
        start_run();
        finish_run("srst_keep_mask", 10, 9, 1, 1'b0);
        check("srst_keep_first", 64'(tx_at(tx_base)), 64'h305);

        // Hard reset while waiting in the send state.
        configure(32'h0000_FFFF, 32'h0000_0005, 0, 1);
        fill_ramp(32'h0000_0000);
        tx_rdy_i = 1'b0;
        start_run();
        repeat (15) tick();
        check("rst_wait_nostrobe", 64'(tx_q.size() - tx_base), 64'd0);
        rst_in = 1'b1;
        tick();
        rst_in   = 1'b0;
        tx_rdy_i = 1'b1;
        #1;
        check("rst_outputs", 64'({we_o, addr_o, tx_stb_o}), 64'd0);
        check("rst_tx_o", 64'(tx_o), 64'd0);
        finish_run("rst_abort", 6, 0, 0, 1'b0);
        fill_ramp(32'h0000_0040);
        start_run();
        finish_run("rst_cfg_cleared", 1, 0, 1, 1'b0);

        // Randomized captures against the model.
        for (int r = 0; r < 6; r++) begin
            m  = (32'd1 << $urandom_range(0, 31)) | (32'd1 << $urandom_range(0, 31));
            v  = $urandom;
            d  = $urandom_range(0, 31);
            rc = $urandom_range(1, 32);
            for (int k = 0; k < STIM_N; k++) stim[k] = $urandom;
            stim[60] = v;
            last = find_last(m, v, d);
            configure(m, v, d, rc);
            start_run();
            finish_run($sformatf("rand%0d", r), last + 1, last, rc, 1'b1);
        end

        check("tx_stb_rules", 64'(viol), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
